// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared constants and types for the fetch front end.
//   PC_RESET        : first PC fetched after reset
//   INST_NOP        : instruction word presented when no instruction is valid
//   FETCH_BUF_DEPTH : number of fetch-buffer entries (fixed at 2)
//   fetch_entry_t   : one fetch-buffer entry, {pc, word}
//   next_pc()       : sequential successor of a PC (wraps mod 2^32)
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] PC_RESET        = 32'h0000_3000;
    localparam logic [31:0] INST_NOP        = 32'h0000_0000;
    localparam int unsigned FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Two-entry FIFO of {pc, word} pairs between instruction memory and decode.
//   Ports:
//     clk, resetN  : clock, synchronous active-low reset
//     push         : write push_entry at the tail
//     push_entry   : {pc, word} to store
//     pop          : drop the head entry
//     clear        : discard all entries; wins over push and pop
//     full, empty  : occupancy flags
//     count        : number of valid entries (0..2)
//     head         : oldest entry, valid when !empty
// -----------------------------------------------------------------------------
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         resetN,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         clear,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!resetN || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Payload storage needs no reset: entries are only visible through cnt.
    always_ff @(posedge clk) begin
        if (resetN && !clear && do_push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;
    assign head  = entries[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch front end: owns the architectural PC, issues instruction-memory reads
//   (at most one outstanding), buffers returned words and hands {pc, instruction}
//   pairs to decode. A redirect reloads the PC and discards wrong-path state.
//   Ports:
//     clk, resetN                 : clock, synchronous active-low reset
//     imemReqValid/Ready/Addr     : read request channel (word-aligned address)
//     imemRespValid/Data          : in-order read data, >=1 cycle after accept
//     redirectValid/redirectPC    : PC redirect from next-PC logic
//     instValid/instReady         : fetch-buffer head handshake with decode
//     instPC/instruction          : head entry; 0 / nop when instValid=0
//   Handshakes: a transfer happens on a rising edge where valid && ready. Once
//   imemReqValid is raised it stays high with a stable address until accepted;
//   only a redirect may change the address (or drop the request). A decode
//   transfer in a redirect cycle is cancelled: the buffer is flushed instead.
//   The FSM state is held in 'state' for observation.
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PC_RESET,
    parameter int unsigned BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instPC,
    output logic [31:0] instruction
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] DEPTH  = BUF_DEPTH[1:0];

    logic [1:0]   state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         drop_pending;

    logic         req_valid;
    logic         accept;
    logic         push;
    logic         pop;
    logic         still_outstanding;
    logic [1:0]   count_next;
    logic         buf_full;
    logic         buf_empty;
    logic [1:0]   buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirectPC[1:0];

    // All outputs are forced low while reset is asserted, whatever the state.
    assign req_valid    = resetN && (state == S_REQ);
    assign accept       = req_valid && imemReqReady;
    assign imemReqValid = req_valid;
    assign imemReqAddr  = req_valid ? fetch_pc : 32'h0;

    assign instValid    = resetN && !buf_empty;
    assign instPC       = instValid ? buf_head.pc   : 32'h0;
    assign instruction  = instValid ? buf_head.word : INST_NOP;

    assign pop  = instValid && instReady && !redirectValid;
    assign push = resetN && (state == S_WAIT) && imemRespValid && !drop_pending
                  && !redirectValid && (!buf_full || pop);
    assign push_entry = '{pc: req_pc, word: imemRespData};

    // Occupancy after this cycle's push/pop decides whether another read fits.
    assign count_next = buf_count + {1'b0, push} - {1'b0, pop};

    // A request is still in flight after this edge if we are waiting and its
    // data has not arrived yet, or if a new request is being accepted now. A
    // response arriving in a redirect cycle is simply discarded.
    assign still_outstanding = ((state == S_WAIT) && !imemRespValid) || accept;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= S_REQ;
            fetch_pc     <= RESET_PC;
            req_pc       <= RESET_PC;
            drop_pending <= 1'b0;
        end else if (redirectValid) begin
            fetch_pc     <= {redirectPC[31:2], 2'b00};
            state        <= still_outstanding ? S_WAIT : S_REQ;
            drop_pending <= still_outstanding;
        end else begin
            case (state)
                S_REQ: begin
                    if (imemReqReady) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= next_pc(fetch_pc);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imemRespValid) begin
                        drop_pending <= 1'b0;
                        state        <= (count_next < DEPTH) ? S_REQ : S_FULL;
                    end
                end
                S_FULL: begin
                    if (pop) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .resetN     (resetN),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (redirectValid),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count),
        .head       (buf_head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed scenarios plus a randomized phase. The reference model is the
//   architectural instruction stream: from the last reset/redirect target, the
//   words consumed by decode are consecutive PCs with memory contents, so a
//   restart refills exp_q with that sequence and the monitor pops on every
//   decode transfer.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        imemReqValid;
    logic        imemReqReady = 1'b0;
    logic [31:0] imemReqAddr;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = 32'h0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPC = 32'h0;
    logic        instValid;
    logic        instReady = 1'b0;
    logic [31:0] instPC;
    logic [31:0] instruction;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_consumed = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic        mem_hold = 1'b0;
    logic        mem_rand = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .resetN        (resetN),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemReqAddr   (imemReqAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .instValid     (instValid),
        .instReady     (instReady),
        .instPC        (instPC),
        .instruction   (instruction)
    );

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        logic [31:0] p;
        p = {pc[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({p, mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero();
        check("rst_req",  {imemReqValid, imemReqAddr}, 64'h0);
        check("rst_inst", {instValid, instPC}, 64'h0);
        check("rst_word", instruction, 64'h0);
    endtask

    // Leaves resetN=1 driven at posedge+1 of the first run cycle.
    task automatic apply_reset(input int n);
        step();
        resetN = 1'b0;
        redirectValid = 1'b0;
        model_restart(32'h0000_3000);
        repeat (n) begin
            @(negedge clk);
            check_all_zero();
            step();
        end
        resetN = 1'b1;
    endtask

    // ---------------- memory model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (resetN && imemReqValid && imemReqReady) begin
                check("one_outstanding", mem_q.size(), 64'd0);
                mem_q.push_back(imemReqAddr);
            end
        end
    end

    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #2;
            if (!resetN) begin
                mem_q.delete();
                imemRespValid = 1'b0;
            end else if (mem_q.size() > 0 && !mem_hold &&
                         (!mem_rand || $urandom_range(0, 1) == 1)) begin
                a = mem_q.pop_front();
                imemRespValid = 1'b1;
                imemRespData  = mem_word(a);
            end else begin
                imemRespValid = 1'b0;
                imemRespData  = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_valid, prev_ready, prev_redirect, prev_rst;
        logic [31:0] prev_addr;
        logic [63:0] e;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_redirect = 1'b0;
        prev_rst = 1'b0; prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (resetN) begin
                if (imemReqValid) check("req_align", imemReqAddr[1:0], 64'h0);
                if (!instValid) check("idle_inst_zero", {instPC, instruction}, 64'h0);
                if (prev_rst && prev_valid && !prev_ready && !prev_redirect) begin
                    check("req_hold_valid", imemReqValid, 64'h1);
                    check("req_hold_addr", imemReqAddr, prev_addr);
                end
                if (instValid && instReady && !redirectValid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL inst_stream: got pc %h, expected queue empty", instPC);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_stream", {instPC, instruction}, e);
                        n_consumed++;
                    end
                end
            end
            prev_valid    = imemReqValid;
            prev_ready    = imemReqReady;
            prev_redirect = redirectValid;
            prev_rst      = resetN;
            prev_addr     = imemReqAddr;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int          after_redir;
        logic        check_now;
        int          consumed_before;
        logic [31:0] tgt;

        // 1: 1-cycle memory, requests every second cycle, stream in order
        imemReqReady = 1'b1;
        instReady    = 1'b1;
        apply_reset(3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_req_valid", imemReqValid, 64'((k % 2) == 0));
            if ((k % 2) == 0) check("t1_req_addr", imemReqAddr, 64'(32'h3000 + 32'(2 * k)));
        end
        repeat (12) step();

        // 2: decode stalls, two words buffered, FSM in FULL
        instReady = 1'b0;
        apply_reset(2);
        repeat (10) step();
        @(negedge clk);
        check("t2_full_no_req", imemReqValid, 64'h0);
        check("t2_head_valid", instValid, 64'h1);
        check("t2_head_pc", instPC, 64'h3000);
        step();
        instReady = 1'b1;
        @(negedge clk);
        check("t2_drain0_pc", instPC, 64'h3000);
        check("t2_drain0_req", imemReqValid, 64'h0);
        step();
        @(negedge clk);
        check("t2_drain1_pc", instPC, 64'h3004);
        check("t2_next_req", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3008});
        step();
        @(negedge clk);
        check("t2_empty", instValid, 64'h0);
        repeat (8) step();

        // 3: memory not ready, request held stable
        imemReqReady = 1'b0;
        apply_reset(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3000});
        end
        step();
        imemReqReady = 1'b1;
        repeat (6) step();

        // 4: redirect while waiting for a response
        mem_hold = 1'b1;
        apply_reset(2);
        step();
        step();
        redirectValid = 1'b1;
        redirectPC    = 32'h0000_3100;
        model_restart(32'h0000_3100);
        step();
        redirectValid = 1'b0;
        mem_hold      = 1'b0;
        @(negedge clk);
        check("t4_inst_flushed", instValid, 64'h0);
        check("t4_waiting_drop", imemReqValid, 64'h0);
        step();
        @(negedge clk);
        check("t4_new_req", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3100});
        repeat (10) step();

        // 5: redirect with a full buffer and nothing outstanding
        instReady = 1'b0;
        apply_reset(2);
        repeat (8) step();
        @(negedge clk);
        check("t5_buffered", {instValid, imemReqValid}, 64'h2);
        step();
        redirectValid = 1'b1;
        redirectPC    = 32'h0000_3203;
        model_restart(32'h0000_3203);
        step();
        redirectValid = 1'b0;
        @(negedge clk);
        check("t5_flushed", instValid, 64'h0);
        check("t5_new_req", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3200});
        step();
        instReady = 1'b1;
        repeat (10) step();

        // 6: redirect coincident with a response and a decode handshake
        instReady = 1'b0;
        apply_reset(2);
        step();
        step();
        step();
        redirectValid = 1'b1;
        redirectPC    = 32'h0000_3300;
        instReady     = 1'b1;
        model_restart(32'h0000_3300);
        @(negedge clk);
        check("t6_head_present", instValid, 64'h1);
        step();
        redirectValid = 1'b0;
        @(negedge clk);
        check("t6_flushed", instValid, 64'h0);
        check("t6_new_req", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3300});
        repeat (7) step();
        apply_reset(2);
        @(negedge clk);
        check("t6_restart", {imemReqValid, imemReqAddr}, {31'h0, 1'b1, 32'h3000});

        // randomized phase
        mem_rand        = 1'b1;
        after_redir     = 0;
        consumed_before = n_consumed;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            redirectValid = 1'b0;
            check_now     = (after_redir != 0);
            after_redir   = 0;
            if ($urandom_range(0, 599) == 0) begin
                apply_reset(2);
                check_now = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else tgt = $urandom;
                redirectValid = 1'b1;
                redirectPC    = tgt;
                model_restart(tgt);
                after_redir   = 1;
            end
            imemReqReady = ($urandom_range(0, 3) != 0);
            instReady    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (check_now) check("rand_redir_flush", instValid, 64'h0);
        end
        step();
        redirectValid = 1'b0;
        mem_rand      = 1'b0;
        imemReqReady  = 1'b1;
        instReady     = 1'b1;
        repeat (20) step();
        check("rand_progress", 64'(n_consumed - consumed_before > 200), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
